// File: rtl/seg_rx.sv
// Seven-segment display receiver: synchronizes observed seg/an lines, waits for a stable
// window, decodes the active digit. Optional decimal-point capture under SEG_RX_DP_EN.
module seg_rx #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     an,
`ifdef SEG_RX_DP_EN
    input  logic                dp,
    output logic [NDIG-1:0]     dp_out,
`endif
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     digit_valid,
    output logic                upd,
    output logic                err
);

`ifdef SEG_RX_DP_EN
    localparam int SW = NDIG + 8;
`else
    localparam int SW = NDIG + 7;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HELD  = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        // bit 4 flags a recognised glyph, bits 3:0 carry the nibble
        case (pat)
            7'h01:   return 5'h10;
            7'h4F:   return 5'h11;
            7'h12:   return 5'h12;
            7'h06:   return 5'h13;
            7'h4C:   return 5'h14;
            7'h24:   return 5'h15;
            7'h20:   return 5'h16;
            7'h0F:   return 5'h17;
            7'h00:   return 5'h18;
            7'h04:   return 5'h19;
            7'h08:   return 5'h1A;
            7'h60:   return 5'h1B;
            7'h31:   return 5'h1C;
            7'h42:   return 5'h1D;
            7'h30:   return 5'h1E;
            7'h38:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic is_one_hot(input logic [NDIG-1:0] v);
        return (v != '0) && ((v & (v - NDIG'(1))) == '0);
    endfunction

    logic [SW-1:0]     raw;
    logic [SW-1:0]     sync1_q;
    logic [SW-1:0]     sync2_q;
    logic [SW-1:0]     prev_q;
    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              eval;
    logic              same;

    logic [NDIG-1:0]   an_s;
    logic [NDIG-1:0]   an_low;
    logic [6:0]        seg_s;
    logic [4:0]        dec;
    logic              one_hot;

    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              upd_q, upd_d;
    logic              err_q, err_d;

`ifdef SEG_RX_DP_EN
    logic              dp_s;
    logic [NDIG-1:0]   dp_q, dp_d;

    assign raw  = {an, dp, seg};
    assign dp_s = sync2_q[7];
`else
    assign raw  = {an, seg};
`endif

    assign an_s    = sync2_q[SW-1 -: NDIG];
    assign seg_s   = sync2_q[6:0];
    assign an_low  = ~an_s;
    assign dec     = seg_decode(seg_s);
    assign one_hot = is_one_hot(an_low);
    assign same    = (sync2_q == prev_q);

    // Synchronizers idle at all ones, i.e. every line inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eval    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_COUNT;
                cnt_d   = 8'd0;
            end
            ST_COUNT: begin
                if (!same) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    eval    = 1'b1;
                    state_d = ST_HELD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HELD: begin
                if (!same) begin
                    state_d = ST_COUNT;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only a single active digit may touch a slot; ghosting (several enables) just flags err.
    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
`ifdef SEG_RX_DP_EN
        dp_d    = dp_q;
`endif
        if (eval) begin
            if (one_hot) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (an_low[i]) begin
                        if (dec[4]) begin
                            value_d[4*i +: 4] = dec[3:0];
                            valid_d[i]        = 1'b1;
`ifdef SEG_RX_DP_EN
                            dp_d[i]           = ~dp_s;
`endif
                        end else begin
                            valid_d[i] = 1'b0;
                        end
                    end
                end
                upd_d = dec[4];
                err_d = ~dec[4];
            end else if (an_low != '0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            valid_q <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

`ifdef SEG_RX_DP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q <= '0;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp_out = dp_q;
`endif

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign upd         = upd_q;
    assign err         = err_q;

endmodule
